// File: rtl/aaxi_pkg.sv
// Shared definitions for the aaxi request/response bridge: field widths,
// the captured request payload and the bridge FSM state encoding.
package aaxi_pkg;

    localparam int unsigned AAXI_ADDR_MSB = 31;
    localparam int unsigned AAXI_ADDR_LSB = 2;
    localparam int unsigned AAXI_ADDR_W   = AAXI_ADDR_MSB - AAXI_ADDR_LSB + 1;
    localparam int unsigned AAXI_DATA_W   = 32;
    localparam int unsigned AAXI_STRB_W   = 4;

    // Request payload as captured from the upstream port.
    typedef struct packed {
        logic                   we;
        logic [AAXI_ADDR_W-1:0] addr;
        logic [AAXI_DATA_W-1:0] data;
        logic [AAXI_STRB_W-1:0] strb;
    } aaxi_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } aaxi_state_e;

endpackage : aaxi_pkg

// File: rtl/aaxi_sync_bridge_if.sv
// Signal bundle for both sides of the aaxi sync bridge.
//   s_* : upstream port (request pulse in, response pulse out)
//   m_* : downstream port (request valid/ready out, response pulse in)
// Modports:
//   slave  - the bridge itself (target of the upstream initiator,
//            initiator towards the downstream target)
//   master - the surrounding environment driving s_* requests and m_* responses
interface aaxi_sync_bridge_if;
    import aaxi_pkg::*;

    logic                   s_avalid;
    logic                   s_awe;
    logic [AAXI_ADDR_W-1:0] s_aaddr;
    logic [AAXI_DATA_W-1:0] s_adata;
    logic [AAXI_STRB_W-1:0] s_astrb;
    logic                   s_bvalid;
    logic [AAXI_DATA_W-1:0] s_bdata;

    logic                   m_avalid;
    logic                   m_aready;
    logic                   m_awe;
    logic [AAXI_ADDR_W-1:0] m_aaddr;
    logic [AAXI_DATA_W-1:0] m_adata;
    logic [AAXI_STRB_W-1:0] m_astrb;
    logic                   m_bvalid;
    logic [AAXI_DATA_W-1:0] m_bdata;

    modport slave (
        input  s_avalid, s_awe, s_aaddr, s_adata, s_astrb,
        output s_bvalid, s_bdata,
        output m_avalid, m_awe, m_aaddr, m_adata, m_astrb,
        input  m_aready, m_bvalid, m_bdata
    );

    modport master (
        output s_avalid, s_awe, s_aaddr, s_adata, s_astrb,
        input  s_bvalid, s_bdata,
        input  m_avalid, m_awe, m_aaddr, m_adata, m_astrb,
        output m_aready, m_bvalid, m_bdata
    );

endinterface : aaxi_sync_bridge_if

// File: rtl/aaxi_sync_bridge.sv
// Single-clock aaxi request/response bridge. Captures an upstream request
// pulse, presents it downstream under valid/ready, waits for the downstream
// response pulse and returns it upstream as a one-cycle pulse. One
// transaction outstanding at a time; upstream requests while busy are dropped.
// Ports:
//   clk   - rising-edge clock for both sides
//   rst_n - asynchronous active-low reset; aborts any transaction in flight
//   bus   - s_* upstream and m_* downstream signals (slave modport)
module aaxi_sync_bridge
    import aaxi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    aaxi_sync_bridge_if.slave  bus
);

    aaxi_state_e            state_q,  state_d;
    aaxi_req_t              req_q,    req_d;
    logic                   avalid_q, avalid_d;
    logic                   bvalid_q, bvalid_d;
    logic [AAXI_DATA_W-1:0] bdata_q,  bdata_d;

    // State and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= '0;
            avalid_q <= 1'b0;
            bvalid_q <= 1'b0;
            bdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            avalid_q <= avalid_d;
            bvalid_q <= bvalid_d;
            bdata_q  <= bdata_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        avalid_d = avalid_q;
        bvalid_d = 1'b0;
        bdata_d  = bdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.s_avalid) begin
                    req_d    = '{we:   bus.s_awe,
                                 addr: bus.s_aaddr,
                                 data: bus.s_adata,
                                 strb: bus.s_astrb};
                    avalid_d = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.m_aready) begin
                    avalid_d = 1'b0;
                    // A response landing on the handshake edge completes at once.
                    if (bus.m_bvalid) begin
                        bvalid_d = 1'b1;
                        bdata_d  = bus.m_bdata;
                        state_d  = IDLE;
                    end else begin
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.m_bvalid) begin
                    bvalid_d = 1'b1;
                    bdata_d  = bus.m_bdata;
                    state_d  = IDLE;
                end
            end
            default: begin
                avalid_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign bus.m_avalid = avalid_q;
    assign bus.m_awe    = req_q.we;
    assign bus.m_aaddr  = req_q.addr;
    assign bus.m_adata  = req_q.data;
    assign bus.m_astrb  = req_q.strb;
    assign bus.s_bvalid = bvalid_q;
    assign bus.s_bdata  = bdata_q;

endmodule : aaxi_sync_bridge

// File: tb/tb_aaxi_sync_bridge.sv
// Self-checking bench for aaxi_sync_bridge: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a transaction-level
// reference model.
module tb_aaxi_sync_bridge;
    import aaxi_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aaxi_sync_bridge_if bus ();

    aaxi_sync_bridge dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;
    int resp_cnt = 0;

    // Reference model: one outstanding transaction, tracked as
    // "pending" (accepted upstream) and "sent" (handshaken downstream).
    bit                     mdl_pending;
    bit                     mdl_sent;
    aaxi_req_t              mdl_req;
    bit                     exp_mvalid;
    bit                     exp_bvalid;
    logic [AAXI_DATA_W-1:0] exp_bdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_pending = 1'b0;
        mdl_sent    = 1'b0;
        mdl_req     = '0;
        exp_mvalid  = 1'b0;
        exp_bvalid  = 1'b0;
        exp_bdata   = '0;
    endtask

    // Apply the bridge rules for one clock edge using the inputs present at it.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_bvalid = 1'b0;
            if (!mdl_pending) begin
                if (bus.s_avalid) begin
                    mdl_req     = '{we: bus.s_awe, addr: bus.s_aaddr,
                                    data: bus.s_adata, strb: bus.s_astrb};
                    mdl_pending = 1'b1;
                    mdl_sent    = 1'b0;
                    exp_mvalid  = 1'b1;
                end
            end else begin
                if (!mdl_sent && bus.m_aready) begin
                    mdl_sent   = 1'b1;
                    exp_mvalid = 1'b0;
                end
                if (mdl_sent && bus.m_bvalid) begin
                    exp_bvalid  = 1'b1;
                    exp_bdata   = bus.m_bdata;
                    mdl_pending = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("m_avalid", 32'(bus.m_avalid), 32'(exp_mvalid));
        chk("m_awe",    32'(bus.m_awe),    32'(mdl_req.we));
        chk("m_aaddr",  32'(bus.m_aaddr),  32'(mdl_req.addr));
        chk("m_adata",  bus.m_adata,       mdl_req.data);
        chk("m_astrb",  32'(bus.m_astrb),  32'(mdl_req.strb));
        chk("s_bvalid", 32'(bus.s_bvalid), 32'(exp_bvalid));
        chk("s_bdata",  bus.s_bdata,       exp_bdata);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        if (bus.s_bvalid === 1'b1) resp_cnt++;
    endtask

    task automatic clear_inputs();
        bus.s_avalid = 1'b0;
        bus.s_awe    = 1'b0;
        bus.s_aaddr  = '0;
        bus.s_adata  = '0;
        bus.s_astrb  = '0;
        bus.m_aready = 1'b0;
        bus.m_bvalid = 1'b0;
        bus.m_bdata  = '0;
    endtask

    task automatic drive_req(input logic we, input logic [29:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        bus.s_avalid = 1'b1;
        bus.s_awe    = we;
        bus.s_aaddr  = addr;
        bus.s_adata  = data;
        bus.s_astrb  = strb;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_now_m_avalid", 32'(bus.m_avalid), 32'd0);
        check_all();
        step();
        rst_n = 1'b1;
    endtask

    int cnt0;

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Write with immediate accept.
        bus.m_aready = 1'b1;
        drive_req(1'b1, 30'd0, 32'd42, 4'hF);
        step();
        chk("wr_m_avalid", 32'(bus.m_avalid), 32'd1);
        chk("wr_m_awe",    32'(bus.m_awe),    32'd1);
        chk("wr_m_adata",  bus.m_adata,       32'd42);
        chk("wr_m_astrb",  32'(bus.m_astrb),  32'hF);
        bus.s_avalid = 1'b0;
        step();
        chk("wr_m_avalid_drop", 32'(bus.m_avalid), 32'd0);
        bus.m_bvalid = 1'b1;
        bus.m_bdata  = 32'd55;
        step();
        chk("wr_s_bvalid", 32'(bus.s_bvalid), 32'd1);
        chk("wr_s_bdata",  bus.s_bdata,       32'd55);
        bus.m_bvalid = 1'b0;

        // Back-to-back request in the cycle the response is visible.
        drive_req(1'b1, 30'd0, 32'd43, 4'hF);
        step();
        chk("b2b_m_avalid", 32'(bus.m_avalid), 32'd1);
        chk("b2b_m_adata",  bus.m_adata,       32'd43);
        bus.s_avalid = 1'b0;
        bus.m_bvalid = 1'b1;
        bus.m_bdata  = 32'd7;
        step();
        chk("b2b_s_bvalid", 32'(bus.s_bvalid), 32'd1);
        chk("b2b_s_bdata",  bus.s_bdata,       32'd7);
        bus.m_bvalid = 1'b0;

        // Backpressure: three cycles without ready.
        bus.m_aready = 1'b0;
        drive_req(1'b1, 30'd5, 32'd123, 4'h3);
        step();
        bus.s_avalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_m_avalid", 32'(bus.m_avalid), 32'd1);
            chk("bp_m_adata",  bus.m_adata,       32'd123);
            chk("bp_s_bvalid", 32'(bus.s_bvalid), 32'd0);
        end
        bus.m_aready = 1'b1;
        step();
        chk("bp_m_avalid_drop", 32'(bus.m_avalid), 32'd0);
        chk("bp_no_early_resp", 32'(bus.s_bvalid), 32'd0);
        bus.m_bvalid = 1'b1;
        bus.m_bdata  = 32'h77;
        step();
        chk("bp_s_bvalid", 32'(bus.s_bvalid), 32'd1);
        bus.m_bvalid = 1'b0;

        // Read, then a request while waiting for the response.
        cnt0 = resp_cnt;
        drive_req(1'b0, 30'h10, 32'd0, 4'h0);
        step();
        chk("rd_m_awe",   32'(bus.m_awe),   32'd0);
        chk("rd_m_aaddr", 32'(bus.m_aaddr), 32'h10);
        bus.s_avalid = 1'b0;
        step();
        drive_req(1'b1, 30'd3, 32'd99, 4'hF);
        step();
        chk("busy_m_avalid", 32'(bus.m_avalid), 32'd0);
        chk("busy_m_adata",  bus.m_adata,       32'd0);
        bus.s_avalid = 1'b0;
        bus.m_bvalid = 1'b1;
        bus.m_bdata  = 32'hABCD;
        step();
        bus.m_bvalid = 1'b0;
        repeat (3) step();
        chk("busy_one_resp", 32'(resp_cnt - cnt0), 32'd1);
        chk("busy_no_reissue", 32'(bus.m_avalid), 32'd0);

        // Stray response in IDLE, then reset during REQ.
        bus.m_bvalid = 1'b1;
        bus.m_bdata  = 32'h1234;
        step();
        chk("stray_s_bvalid", 32'(bus.s_bvalid), 32'd0);
        bus.m_bvalid = 1'b0;
        bus.m_aready = 1'b0;
        drive_req(1'b1, 30'h3FF, 32'hDEAD, 4'h5);
        step();
        bus.s_avalid = 1'b0;
        chk("rst_pre_m_avalid", 32'(bus.m_avalid), 32'd1);
        async_reset_pulse();
        cnt0 = resp_cnt;
        bus.m_aready = 1'b1;
        bus.m_bvalid = 1'b1;
        repeat (3) step();
        chk("rst_no_resp", 32'(resp_cnt - cnt0), 32'd0);
        bus.m_bvalid = 1'b0;

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            bus.s_avalid = ($urandom_range(99) < 30);
            bus.s_awe    = 1'($urandom);
            bus.s_aaddr  = 30'($urandom);
            bus.s_adata  = $urandom;
            bus.s_astrb  = 4'($urandom);
            bus.m_aready = ($urandom_range(99) < 50);
            bus.m_bvalid = ($urandom_range(99) < 30);
            bus.m_bdata  = $urandom;
            if ($urandom_range(299) == 0) async_reset_pulse();
            else step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_aaxi_sync_bridge
